// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: ID-stage instruction fields, pipeline hold and
// branch resolution flowing into the scoreboard; stall/flush/forward
// selects and event counters flowing back to the pipeline.
//   master : pipeline control side (drives ID fields, freeze, branch_taken)
//   slave  : hazard_scoreboard
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  freeze;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_src1_use;
    logic                  id_src2_use;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_wb_en;
    logic                  id_mem_read;
    logic                  id_status_we;
    logic                  id_uses_status;
    logic                  branch_taken;
    logic                  stall;
    logic                  flush;
    logic [2:0]            fwd_sel1;
    logic [2:0]            fwd_sel2;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output freeze, id_valid, id_src1, id_src2, id_src1_use, id_src2_use,
               id_dest, id_wb_en, id_mem_read, id_status_we, id_uses_status,
               branch_taken,
        input  stall, flush, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
    );

    modport slave (
        input  freeze, id_valid, id_src1, id_src2, id_src1_use, id_src2_use,
               id_dest, id_wb_en, id_mem_read, id_status_we, id_uses_status,
               branch_taken,
        output stall, flush, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard. Tracks the destinations of the DEPTH
// instructions downstream of ID (entry 0 = EXE ... DEPTH-1 = WB) and
// decides, with zero latency, whether the instruction in ID must stall
// or which stage result it should forward from.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   sb  : hazard_scoreboard_if slave (ID fields, freeze, branch_taken in;
//         stall, flush, fwd_sel1/2, stall_cnt, flush_cnt out)
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 3,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
        logic                  status_we;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t           pipe_q [DEPTH];
    entry_t           id_entry;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;
    logic [2:0]       first1;
    logic [2:0]       first2;
    logic             load_use1;
    logic             load_use2;
    logic             raw_haz;
    logic             status_haz;
    logic             stall_int;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match1[k] = sb.id_src1_use && pipe_q[k].valid && pipe_q[k].wb_en
                        && (pipe_q[k].dest == sb.id_src1);
            match2[k] = sb.id_src2_use && pipe_q[k].valid && pipe_q[k].wb_en
                        && (pipe_q[k].dest == sb.id_src2);
        end
    end

    // Scan oldest to youngest so the youngest producer overwrites last.
    always_comb begin
        first1 = '0;
        first2 = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match1[k]) first1 = 3'(k + 1);
            if (match2[k]) first2 = 3'(k + 1);
        end
    end

    // A load in EXE is the youngest producer whenever it matches, so its
    // data cannot be forwarded this cycle; older loads have their data.
    assign load_use1  = match1[0] && pipe_q[0].mem_read;
    assign load_use2  = match2[0] && pipe_q[0].mem_read;
    assign raw_haz    = (FWD_EN != 0) ? (load_use1 || load_use2)
                                      : ((|match1) || (|match2));
    assign status_haz = sb.id_uses_status && pipe_q[0].valid && pipe_q[0].status_we;

    // A taken branch squashes ID, so a hazard there is irrelevant.
    assign stall_int  = sb.id_valid && !sb.branch_taken && (raw_haz || status_haz);

    assign sb.stall    = stall_int;
    assign sb.flush    = sb.branch_taken;
    assign sb.fwd_sel1 = ((FWD_EN != 0) && !stall_int && !load_use1) ? first1 : 3'd0;
    assign sb.fwd_sel2 = ((FWD_EN != 0) && !stall_int && !load_use2) ? first2 : 3'd0;
    assign sb.stall_cnt = stall_cnt_q;
    assign sb.flush_cnt = flush_cnt_q;

    always_comb begin
        id_entry = '0;
        if (sb.id_valid && !stall_int && !sb.branch_taken) begin
            id_entry.valid     = 1'b1;
            id_entry.dest      = sb.id_dest;
            id_entry.wb_en     = sb.id_wb_en;
            id_entry.mem_read  = sb.id_mem_read;
            id_entry.status_we = sb.id_status_we;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) pipe_q[k] <= '0;
        end else if (!sb.freeze) begin
            pipe_q[0] <= id_entry;
            for (int k = 1; k < DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!sb.freeze) begin
            if (stall_int && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (sb.branch_taken && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Three scoreboards share one stimulus stream:
//   inst 0 : forwarding, 16-bit counters
//   inst 1 : stall-only, 16-bit counters
//   inst 2 : stall-only, 2-bit counters
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       freeze, id_valid, bt;
    logic [3:0] src1, src2, dest;
    logic       use1, use2, wb, ld, stw, us;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(4), .CNT_W(16)) if0 ();
    hazard_scoreboard_if #(.REG_ADDR_W(4), .CNT_W(16)) if1 ();
    hazard_scoreboard_if #(.REG_ADDR_W(4), .CNT_W(2))  if2 ();

    assign {if0.freeze, if0.id_valid, if0.id_src1, if0.id_src2, if0.id_src1_use, if0.id_src2_use,
            if0.id_dest, if0.id_wb_en, if0.id_mem_read, if0.id_status_we, if0.id_uses_status,
            if0.branch_taken} = {freeze, id_valid, src1, src2, use1, use2, dest, wb, ld, stw, us, bt};
    assign {if1.freeze, if1.id_valid, if1.id_src1, if1.id_src2, if1.id_src1_use, if1.id_src2_use,
            if1.id_dest, if1.id_wb_en, if1.id_mem_read, if1.id_status_we, if1.id_uses_status,
            if1.branch_taken} = {freeze, id_valid, src1, src2, use1, use2, dest, wb, ld, stw, us, bt};
    assign {if2.freeze, if2.id_valid, if2.id_src1, if2.id_src2, if2.id_src1_use, if2.id_src2_use,
            if2.id_dest, if2.id_wb_en, if2.id_mem_read, if2.id_status_we, if2.id_uses_status,
            if2.branch_taken} = {freeze, id_valid, src1, src2, use1, use2, dest, wb, ld, stw, us, bt};

    hazard_scoreboard #(.REG_ADDR_W(4), .DEPTH(3), .FWD_EN(1), .CNT_W(16))
        dut0 (.clk(clk), .rst(rst), .sb(if0.slave));
    hazard_scoreboard #(.REG_ADDR_W(4), .DEPTH(3), .FWD_EN(0), .CNT_W(16))
        dut1 (.clk(clk), .rst(rst), .sb(if1.slave));
    hazard_scoreboard #(.REG_ADDR_W(4), .DEPTH(3), .FWD_EN(0), .CNT_W(2))
        dut2 (.clk(clk), .rst(rst), .sb(if2.slave));

    // ---------------- reference model ----------------
    typedef struct {
        bit valid;
        int dest;
        bit wb;
        bit ld;
        bit st;
    } m_entry_t;

    m_entry_t mp [3][3];        // [instance][age], age 0 = EXE
    int       m_scnt [3];
    int       m_fcnt [3];
    bit       m_fwd  [3] = '{1'b1, 1'b0, 1'b0};
    int       m_max  [3] = '{65535, 65535, 3};

    // Youngest in-flight producer of a register, or -1 when none.
    function automatic int youngest(int i, bit used, int r);
        if (!used) return -1;
        for (int a = 0; a < 3; a++)
            if (mp[i][a].valid && mp[i][a].wb && mp[i][a].dest == r) return a;
        return -1;
    endfunction

    function automatic void model_eval(int i, output bit st, output int s1, output int s2);
        int  p1, p2;
        bit  wait1, wait2, need_stall;
        p1 = youngest(i, use1, int'(src1));
        p2 = youngest(i, use2, int'(src2));
        if (m_fwd[i]) begin
            wait1 = (p1 == 0) && mp[i][0].ld;
            wait2 = (p2 == 0) && mp[i][0].ld;
        end else begin
            wait1 = (p1 >= 0);
            wait2 = (p2 >= 0);
        end
        need_stall = wait1 || wait2 || (us && mp[i][0].valid && mp[i][0].st);
        st = id_valid && !bt && need_stall;
        s1 = (m_fwd[i] && !st && p1 >= 0 && !wait1) ? p1 + 1 : 0;
        s2 = (m_fwd[i] && !st && p2 >= 0 && !wait2) ? p2 + 1 : 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        bit st;
        int s1, s2;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int a = 0; a < 3; a++) mp[i][a] = '{0, 0, 0, 0, 0};
                m_scnt[i] = 0;
                m_fcnt[i] = 0;
            end
        end else if (!freeze) begin
            for (int i = 0; i < 3; i++) begin
                model_eval(i, st, s1, s2);
                for (int a = 2; a > 0; a--) mp[i][a] = mp[i][a-1];
                if (id_valid && !st && !bt)
                    mp[i][0] = '{1, int'(dest), wb, ld, stw};
                else
                    mp[i][0] = '{0, 0, 0, 0, 0};
                if (st && m_scnt[i] < m_max[i]) m_scnt[i]++;
                if (bt && m_fcnt[i] < m_max[i]) m_fcnt[i]++;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(int i, logic st, logic fl, logic [2:0] f1, logic [2:0] f2,
                       logic [31:0] sc, logic [31:0] fc);
        bit es;
        int e1, e2;
        model_eval(i, es, e1, e2);
        chk($sformatf("i%0d.stall", i), 32'(st), 32'(es));
        chk($sformatf("i%0d.flush", i), 32'(fl), 32'(bt));
        chk($sformatf("i%0d.fwd_sel1", i), 32'(f1), e1);
        chk($sformatf("i%0d.fwd_sel2", i), 32'(f2), e2);
        chk($sformatf("i%0d.stall_cnt", i), sc, m_scnt[i]);
        chk($sformatf("i%0d.flush_cnt", i), fc, m_fcnt[i]);
    endtask

    always @(negedge clk) begin
        cmp(0, if0.stall, if0.flush, if0.fwd_sel1, if0.fwd_sel2, 32'(if0.stall_cnt), 32'(if0.flush_cnt));
        cmp(1, if1.stall, if1.flush, if1.fwd_sel1, if1.fwd_sel2, 32'(if1.stall_cnt), 32'(if1.flush_cnt));
        cmp(2, if2.stall, if2.flush, if2.fwd_sel1, if2.fwd_sel2, 32'(if2.stall_cnt), 32'(if2.flush_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; src1 = 0; src2 = 0; use1 = 0; use2 = 0;
        dest = 0; wb = 0; ld = 0; stw = 0; us = 0;
    endtask

    task automatic issue(int s1, bit u1, int s2, bit u2, int d, bit w, bit l, bit sw, bit u);
        id_valid = 1; src1 = 4'(s1); use1 = u1; src2 = 4'(s2); use2 = u2;
        dest = 4'(d); wb = w; ld = l; stw = sw; us = u;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        freeze = 0; bt = 0;
        idle();
        #1 rst = 0;
        tick(); tick();
        bt = 1; settle();
        chk("rst.flush", 32'(if0.flush), 1);
        chk("rst.stall", 32'(if0.stall), 0);
        chk("rst.fwd_sel1", 32'(if0.fwd_sel1), 0);
        chk("rst.stall_cnt", 32'(if0.stall_cnt), 0);
        bt = 0;
        tick();
        rst = 1;

        // forwarding: ADD R1 then three consumers of R1
        issue(0, 0, 0, 0, 1, 1, 0, 0, 0); tick();
        issue(1, 1, 0, 0, 8, 0, 0, 0, 0); settle();
        chk("fwd.sel1_ex", 32'(if0.fwd_sel1), 1);
        chk("fwd.stall", 32'(if0.stall), 0);
        tick(); chk("fwd.sel1_mem", 32'(if0.fwd_sel1), 2);
        tick(); chk("fwd.sel1_wb", 32'(if0.fwd_sel1), 3);
        tick(); chk("fwd.sel1_gone", 32'(if0.fwd_sel1), 0);
        drain();

        // load-use: LDR R2 then consumer of R2
        issue(0, 0, 0, 0, 2, 1, 1, 0, 0); tick();
        issue(0, 0, 2, 1, 9, 0, 0, 0, 0); settle();
        chk("lu.stall", 32'(if0.stall), 1);
        chk("lu.sel2_stalled", 32'(if0.fwd_sel2), 0);
        tick();
        chk("lu.stall_after", 32'(if0.stall), 0);
        chk("lu.sel2", 32'(if0.fwd_sel2), 2);
        chk("lu.stall_cnt", 32'(if0.stall_cnt), 1);
        tick();
        drain();

        // stall-only: R3 producer, back-to-back consumer
        issue(0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
        issue(3, 1, 0, 0, 10, 0, 0, 0, 0); settle();
        chk("so.stall_c0", 32'(if1.stall), 1);
        tick(); chk("so.stall_c1", 32'(if1.stall), 1);
        tick(); chk("so.stall_c2", 32'(if1.stall), 1);
        tick();
        chk("so.stall_end", 32'(if1.stall), 0);
        chk("so.sel1", 32'(if1.fwd_sel1), 0);
        drain();

        // taken branch with a load-use hazard in ID (ID is itself LDR R2)
        issue(0, 0, 0, 0, 2, 1, 1, 0, 0); tick();
        issue(0, 0, 2, 1, 2, 1, 1, 0, 0); bt = 1; settle();
        chk("br.flush", 32'(if0.flush), 1);
        chk("br.stall", 32'(if0.stall), 0);
        tick();
        bt = 0;
        issue(0, 0, 2, 1, 9, 0, 0, 0, 0); settle();
        chk("br.flush_cnt", 32'(if0.flush_cnt), 1);
        chk("br.bubble_stall", 32'(if0.stall), 0);
        chk("br.bubble_sel2", 32'(if0.fwd_sel2), 2);
        tick();
        drain();

        // status flags: CMP then conditional
        issue(0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 1); settle();
        chk("st.stall_fwd", 32'(if0.stall), 1);
        chk("st.stall_so", 32'(if1.stall), 1);
        tick();
        chk("st.clear", 32'(if0.stall), 0);
        drain();

        // freeze during a load-use stall
        issue(0, 0, 0, 0, 4, 1, 1, 0, 0); tick();
        issue(4, 1, 0, 0, 11, 0, 0, 0, 0); settle();
        chk("fz.stall", 32'(if0.stall), 1);
        freeze = 1;
        repeat (5) begin
            tick();
            chk("fz.stall_hold", 32'(if0.stall), 1);
            chk("fz.cnt_hold", 32'(if0.stall_cnt), 2);
        end
        freeze = 0;
        tick();
        chk("fz.resume_stall", 32'(if0.stall), 0);
        chk("fz.resume_sel1", 32'(if0.fwd_sel1), 2);
        chk("fz.resume_cnt", 32'(if0.stall_cnt), 3);
        drain();

        // 2-bit counter saturation, then asynchronous reset mid-stall
        rst = 0; settle();
        tick();
        rst = 1;
        issue(0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
        issue(5, 1, 0, 0, 6, 1, 0, 0, 0); settle();
        chk("sat.stall", 32'(if2.stall), 1);
        repeat (3) tick();
        chk("sat.cnt3", 32'(if2.stall_cnt), 3);
        chk("sat.stall_clear", 32'(if2.stall), 0);
        tick();
        issue(6, 1, 0, 0, 12, 0, 0, 0, 0); settle();
        chk("sat.stall2", 32'(if2.stall), 1);
        tick(); tick();
        chk("sat.cnt_held", 32'(if2.stall_cnt), 3);
        chk("sat.stall_mid", 32'(if2.stall), 1);
        #1 rst = 0;
        #1;
        chk("arst.stall", 32'(if2.stall), 0);
        chk("arst.stall_cnt", 32'(if2.stall_cnt), 0);
        chk("arst.i0_stall_cnt", 32'(if0.stall_cnt), 0);
        chk("arst.i0_flush_cnt", 32'(if0.flush_cnt), 0);

        // first cycle after release starts from an empty scoreboard
        tick();
        rst = 1;
        issue(0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
        issue(7, 1, 0, 0, 13, 0, 0, 0, 0); settle();
        chk("post.sel1", 32'(if0.fwd_sel1), 1);
        chk("post.i2_cnt", 32'(if2.stall_cnt), 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
